// File: rtl/vmac_pkg.sv
// Shared types and constants for the vector MAC job sequencer.
package vmac_pkg;
  localparam int VMAC_LANES      = 32;
  localparam int VMAC_PIPE_DEPTH = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } vmac_seq_state_t;
endpackage

// File: rtl/vector_mac_seq.sv
// Job sequencer in front of the 32-lane vector_mac: streams cmd_len beats into the MAC,
// waits for the adder tree to drain, then returns mac_out delta as the job sum.
module vector_mac_seq
  import vmac_pkg::*;
#(
  parameter int ACC_WIDTH = 27,
  parameter int VEC_WIDTH = 10,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  input  logic                  beat_valid,
  input  logic [VEC_WIDTH-1:0]  beat_data [VMAC_LANES-1:0],
  input  logic [VMAC_LANES-1:0] beat_sel,
  output logic                  beat_ready,
  output logic [VEC_WIDTH-1:0]  mac_in_data [VMAC_LANES-1:0],
  output logic [VMAC_LANES-1:0] mac_in_sel,
  input  logic [ACC_WIDTH-1:0]  mac_out,
  input  logic                  mac_out_ready,
  output logic                  res_valid,
  output logic [ACC_WIDTH-1:0]  res_data,
  input  logic                  res_ready,
  output logic                  busy
);

  vmac_seq_state_t      r_state, w_next;
  logic [ACC_WIDTH-1:0] r_base;
  logic [ACC_WIDTH-1:0] r_res_data;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 w_cmd_fire;
  logic                 w_beat_fire;

  // Accepting only with the MAC drained keeps in-flight partial sums out of the base snapshot.
  assign cmd_ready   = (r_state == IDLE) && mac_out_ready;
  assign beat_ready  = (r_state == STREAM);
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_beat_fire = beat_valid && beat_ready;

  assign mac_in_data = beat_data;
  assign mac_in_sel  = w_beat_fire ? beat_sel : '0;
  assign res_valid   = (r_state == DONE);
  assign res_data    = r_res_data;
  assign busy        = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_next = (cmd_len == '0) ? DONE : STREAM;
      STREAM:  if (w_beat_fire && (r_remaining == LEN_WIDTH'(1))) w_next = DRAIN;
      DRAIN:   if (mac_out_ready) w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_remaining <= '0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_cmd_fire) begin
          r_base      <= mac_out;
          r_remaining <= cmd_len;
          if (cmd_len == '0) r_res_data <= '0;
        end
        STREAM: if (w_beat_fire) r_remaining <= r_remaining - LEN_WIDTH'(1);
        // Accumulator is never cleared; unsigned wrap makes the delta correct across rollover.
        DRAIN: if (mac_out_ready) r_res_data <= mac_out - r_base;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/vector_mac_seq.md
# vector_mac_seq

Job sequencer in front of the 32-lane `vector_mac` accumulator. Accepts a job (beat count) on a valid/ready command port and streams that many 32-lane beats from an upstream source into the MAC, gating lane selects. It then waits for the adder tree to drain and returns the job's sum on a valid/ready result port. The MAC accumulator is never cleared, so the sum is the difference between the MAC output snapshot at job start and the output at job end.

## Interface
- `ACC_WIDTH`, 27, MAC accumulator / result width
- `VEC_WIDTH`, 10, per-lane data width
- `LEN_WIDTH`, 16, job length field width (beats)

- `clk`  in  1  single clock; everything is rising-edge
- `rst`  in  1  asynchronous, active-low reset; the top level drives the MAC's active-high reset from `~rst`
- `cmd_valid`  in  1  job request
- `cmd_len`  in  LEN_WIDTH  number of beats in the job; 0 is legal
- `cmd_ready`  out  1  high in IDLE when `mac_out_ready`=1
- `beat_valid`  in  1  upstream beat available
- `beat_data`  in  VEC_WIDTH×32 (unpacked [31:0])  lane data
- `beat_sel`  in  32  lane select mask
- `beat_ready`  out  1  high in STREAM
- `mac_in_data`  out  VEC_WIDTH×32  equals `beat_data` (combinational pass-through)
- `mac_in_sel`  out  32  `beat_sel` when a beat transfers this cycle, else 0
- `mac_out`  in  ACC_WIDTH  MAC accumulator
- `mac_out_ready`  in  1  MAC drained flag
- `res_valid`  out  1  result held
- `res_data`  out  ACC_WIDTH  job sum
- `res_ready`  in  1  result consumer ready
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE → (`cmd_valid` & `cmd_ready`):
  - latch `base <= mac_out`.
  - If `cmd_len`=0, go to DONE with `res_data`=0.
  - Otherwise load `remaining <= cmd_len` and go to STREAM.
- STREAM: a beat transfers when `beat_valid`=1; `beat_ready` is always 1 in this state.
  - Each transfer decrements `remaining`.
  - The transfer that brings `remaining` to 0 moves the FSM to DRAIN.
  - A `beat_valid`=0 cycle holds the state with `mac_in_sel`=0.
  - A beat with `beat_sel`=0 still counts as a beat.
- DRAIN: wait for `mac_out_ready`=1, then `res_data <= mac_out - base` (modulo 2^ACC_WIDTH, unsigned wrap) and go to DONE.
- DONE: `res_valid`=1 and `res_data` holds stable until `res_ready`=1, then go to IDLE. No new command is accepted until then.
- Requiring `mac_out_ready` in IDLE guarantees no stale in-flight partial sums are counted in `base`.

## Timing
- Reset values: state IDLE, `res_valid`=0, `res_data`=0, `cmd_ready`=0 until `mac_out_ready` is seen, `beat_ready`=0, `mac_in_sel`=0, `busy`=0, internal counters 0.
- The MAC has a 6-edge path from in_sel to `out`. `mac_out_ready` rises on the same edge `out` absorbs the last non-zero beat.
- If the last beat has a non-zero mask at cycle t, `mac_out_ready` is low from edge t+1 to edge t+6. The result is captured at edge t+7 and `res_valid`=1 in cycle t+7.
- If all beats have zero masks, `mac_out_ready` stays high and DRAIN lasts exactly 1 cycle.
- Minimum job latency, from command accept to `res_valid`:
  - len=0: 1 cycle.
  - len=N with a gapless stream: N+7 cycles.
- Throughput: at most one beat per cycle; no back-to-back job overlap.
- Accumulator wrap: the subtraction is taken mod 2^ACC_WIDTH, so the result is correct as long as the job sum is < 2^ACC_WIDTH.
- Async reset mid-job: the FSM returns to IDLE immediately and the partially streamed job is discarded. The MAC is reset by the same signal.

## Structure
- A shared package `vmac_pkg` holds:
  - the state enum `vmac_seq_state_t` (IDLE, STREAM, DRAIN, DONE);
  - `VMAC_LANES`=32;
  - `VMAC_PIPE_DEPTH`=6.
- No sub-module. The optional integration wrapper `vector_mac_unit` instantiates `vector_mac_seq` and `vector_mac`.

## Test plan
- After reset, wait for `cmd_ready`. Job len=1, all 32 lanes data=1, sel=all-ones → `res_data`=32, `res_valid` at accept+8.
- Job len=4, lane data=1023, sel=all-ones, `res_ready`=0 for 5 cycles → `res_data`=130944, held stable until `res_ready`=1.
- Job len=3 with `beat_valid` toggled every other cycle, data=2, sel=0x0000FFFF → `res_data`=96, exactly 3 transfers, and `mac_in_sel`=0 on idle cycles.
- Job len=0 → `res_valid` 1 cycle after accept, `res_data`=0, and no beats consumed.
- Preload the MAC with `mac_out`=2^27−10 via prior jobs, then a job summing 20 → `res_data`=20 (wrap).
- Assert `rst` low during STREAM of a len=8 job → `beat_ready`, `res_valid`, and `busy` drop immediately. The next job (len=1, sum 5) returns 5.
